// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: register map, CTRL field
// positions, mode encodings and FSM states.
package timer_pkg;

  localparam logic [1:0] TM_CTRL   = 2'd0;
  localparam logic [1:0] TM_PRESET = 2'd1;
  localparam logic [1:0] TM_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev_if.sv
// System-bus responder port of the timer: select, word offset, store strobe,
// store data and combinational read data.
interface timer_dev_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, output addr, output we, output din, input dout);
  modport slave  (input sel, input addr, input we, input din, output dout);
endinterface

// File: rtl/timer_dev.sv
// Programmable countdown timer with CTRL/PRESET/COUNT registers, one-shot or
// periodic operation and a maskable level interrupt.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic        irq
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic wr_en;
  logic ctrl_wr;

  assign wr_en   = bus.sel & bus.we;
  assign ctrl_wr = wr_en && (bus.addr == TM_CTRL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= RESET_PRESET;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q)                state_d = ST_IDLE;
        else if (count_q == 32'd0) state_d = ST_INT;
        else                      count_d = count_q - 32'd1;
      end
      ST_INT: begin
        if (mode_q == MODE_PERIODIC) begin
          state_d = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Software CTRL writes are applied last so they override the hardware En clear.
    if (ctrl_wr) begin
      en_d   = bus.din[CTRL_EN];
      mode_d = bus.din[CTRL_MODE_MSB:CTRL_MODE_LSB];
      im_d   = bus.din[CTRL_IM];
    end
    if (wr_en && (bus.addr == TM_PRESET)) preset_d = bus.din;

    pend_d = (pend_q & ~ctrl_wr) | (state_q == ST_INT);
  end

  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      TM_CTRL:   bus.dout = {28'd0, im_q, mode_q, en_q};
      TM_PRESET: bus.dout = preset_q;
      TM_COUNT:  bus.dout = count_q;
      default:   bus.dout = 32'd0;
    endcase
  end

  assign irq = pend_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register-access vector table, directed
// timing sequences and randomized runs against an arithmetic timing model.
module tb_timer_dev;
  import timer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic irq;

  timer_dev_if bus();

  timer_dev #(.RESET_PRESET(32'h0000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
  } reg_vec_t;

  reg_vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one bus cycle from a point between edges; it lands on the next rising edge.
  task automatic applyStimulus(input logic sel, input logic [1:0] addr,
                               input logic [31:0] din, input logic we);
    bus.sel  = sel;
    bus.addr = addr;
    bus.din  = din;
    bus.we   = we;
    @(posedge clock);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    bus.din = 32'd0;
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b1);
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
    bus.addr = addr;
    #1;
    data = bus.dout;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Reference COUNT k edges after the enabling write, from the period arithmetic.
  function automatic logic [31:0] model_count(input int k, input int n, input bit periodic);
    int j;
    if (k < 2) return 32'd0;
    j = k - 2;
    if (periodic) j = j % (n + 3);
    return (j >= n) ? 32'd0 : 32'(n - j);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ctrl_w;
    logic [31:0] exp_ctrl;
    int          n;
    int          len;
    bit          periodic;

    vecs[0] = '{"preset_wr",        1'b1, TM_PRESET, 32'hDEAD_BEEF, TM_PRESET, 32'hDEAD_BEEF};
    vecs[1] = '{"ctrl_upper_ign",   1'b1, TM_CTRL,   32'hFFFF_FFF0, TM_CTRL,   32'h0000_0000};
    vecs[2] = '{"ctrl_im_mode",     1'b1, TM_CTRL,   32'h0000_000E, TM_CTRL,   32'h0000_000E};
    vecs[3] = '{"count_wr_ign",     1'b1, TM_COUNT,  32'h1234_5678, TM_COUNT,  32'h0000_0000};
    vecs[4] = '{"unmapped_wr_ign",  1'b1, 2'd3,      32'hFFFF_FFFF, 2'd3,      32'h0000_0000};
    vecs[5] = '{"nosel_preset_ign", 1'b0, TM_PRESET, 32'h1111_1111, TM_PRESET, 32'hDEAD_BEEF};
    vecs[6] = '{"preset_wr2",       1'b1, TM_PRESET, 32'h0000_0A5A, TM_PRESET, 32'h0000_0A5A};
    vecs[7] = '{"ctrl_clear",       1'b1, TM_CTRL,   32'h0000_0000, TM_CTRL,   32'h0000_0000};

    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.din = 32'd0;
    reset = 1'b0;
    #12;
    reset = 1'b1;
    @(negedge clock);

    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), rd);
      checkOutput($sformatf("reset_read_%0d", a), rd, 32'd0);
    end
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].addr, vecs[i].din, 1'b1);
      read_reg(vecs[i].rd_addr, rd);
      checkOutput(vecs[i].name, rd, vecs[i].exp_rd);
    end

    $display("[TB] one-shot sequence");
    do_reset();
    write_reg(TM_PRESET, 32'd5);
    write_reg(TM_CTRL, 32'h9);
    wait_edges(8);
    checkOutput("oneshot_irq_early", {31'd0, irq}, 32'd0);
    wait_edges(1);
    checkOutput("oneshot_irq_rise", {31'd0, irq}, 32'd1);
    read_reg(TM_CTRL, rd);
    checkOutput("oneshot_ctrl", rd, 32'h8);
    read_reg(TM_COUNT, rd);
    checkOutput("oneshot_count", rd, 32'd0);

    $display("[TB] periodic sequence");
    do_reset();
    write_reg(TM_PRESET, 32'd3);
    write_reg(TM_CTRL, 32'hB);
    wait_edges(2);
    read_reg(TM_COUNT, rd);
    checkOutput("periodic_load1", rd, 32'd3);
    wait_edges(4);
    checkOutput("periodic_irq_early", {31'd0, irq}, 32'd0);
    wait_edges(1);
    checkOutput("periodic_irq_rise", {31'd0, irq}, 32'd1);
    wait_edges(1);
    read_reg(TM_COUNT, rd);
    checkOutput("periodic_load2", rd, 32'd3);
    write_reg(TM_CTRL, 32'hB);
    wait_edges(1);
    read_reg(TM_COUNT, rd);
    checkOutput("periodic_no_reload", rd, 32'd1);
    checkOutput("periodic_irq_cleared", {31'd0, irq}, 32'd0);
    wait_edges(2);
    checkOutput("periodic_irq_still_low", {31'd0, irq}, 32'd0);
    wait_edges(1);
    checkOutput("periodic_irq_again", {31'd0, irq}, 32'd1);
    wait_edges(1);
    read_reg(TM_COUNT, rd);
    checkOutput("periodic_load3", rd, 32'd3);

    $display("[TB] mask and disable sequences");
    do_reset();
    write_reg(TM_PRESET, 32'd2);
    write_reg(TM_CTRL, 32'h1);
    wait_edges(6);
    checkOutput("masked_irq", {31'd0, irq}, 32'd0);
    read_reg(TM_CTRL, rd);
    checkOutput("masked_ctrl_en_clear", rd, 32'h0);
    wait_edges(3);
    checkOutput("masked_irq_later", {31'd0, irq}, 32'd0);

    do_reset();
    write_reg(TM_PRESET, 32'd2);
    write_reg(TM_CTRL, 32'h1);
    repeat (2) @(posedge clock);
    #1;
    write_reg(TM_CTRL, 32'h0);
    wait_edges(4);
    read_reg(TM_COUNT, rd);
    checkOutput("disable_freeze", rd, 32'd1);

    $display("[TB] collision sequence");
    do_reset();
    write_reg(TM_PRESET, 32'd4);
    write_reg(TM_CTRL, 32'h9);
    repeat (7) @(posedge clock);
    #1;
    write_reg(TM_CTRL, 32'hB);
    @(negedge clock);
    read_reg(TM_CTRL, rd);
    checkOutput("collision_ctrl", rd, 32'hB);
    checkOutput("collision_irq", {31'd0, irq}, 32'd1);

    $display("[TB] preset write during count");
    do_reset();
    write_reg(TM_PRESET, 32'd6);
    write_reg(TM_CTRL, 32'h1);
    repeat (3) @(posedge clock);
    #1;
    write_reg(TM_PRESET, 32'd2);
    wait_edges(1);
    read_reg(TM_COUNT, rd);
    checkOutput("preset_mid_count", rd, 32'd3);
    read_reg(TM_PRESET, rd);
    checkOutput("preset_mid_value", rd, 32'd2);
    wait_edges(4);
    read_reg(TM_CTRL, rd);
    checkOutput("preset_mid_en_held", rd, 32'h1);
    wait_edges(1);
    read_reg(TM_CTRL, rd);
    checkOutput("preset_mid_en_clear", rd, 32'h0);

    $display("[TB] preset zero");
    do_reset();
    write_reg(TM_PRESET, 32'd0);
    write_reg(TM_CTRL, 32'h9);
    wait_edges(3);
    checkOutput("zero_irq_early", {31'd0, irq}, 32'd0);
    wait_edges(1);
    checkOutput("zero_irq_rise", {31'd0, irq}, 32'd1);

    $display("[TB] async reset mid-count");
    do_reset();
    write_reg(TM_PRESET, 32'd10);
    write_reg(TM_CTRL, 32'hB);
    wait_edges(18);
    read_reg(TM_COUNT, rd);
    checkOutput("areset_pre_count", rd, 32'd7);
    checkOutput("areset_pre_irq", {31'd0, irq}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("areset_irq", {31'd0, irq}, 32'd0);
    read_reg(TM_COUNT, rd);
    checkOutput("areset_count", rd, 32'd0);
    read_reg(TM_PRESET, rd);
    checkOutput("areset_preset", rd, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    $display("[TB] randomized runs");
    for (int trial = 0; trial < 24; trial++) begin
      do_reset();
      n        = int'($urandom_range(0, 10));
      ctrl_w   = $urandom() | 32'h1;
      periodic = (ctrl_w[2:1] == MODE_PERIODIC);
      write_reg(TM_PRESET, 32'(n));
      write_reg(TM_CTRL, ctrl_w);
      len = 2 * (n + 3) + 4;
      for (int k = 1; k <= len; k++) begin
        wait_edges(1);
        read_reg(TM_COUNT, rd);
        checkOutput($sformatf("rand%0d_count_k%0d", trial, k), rd, model_count(k, n, periodic));
        checkOutput($sformatf("rand%0d_irq_k%0d", trial, k), {31'd0, irq},
                    {31'd0, (ctrl_w[3] && k >= n + 4)});
        exp_ctrl = {28'd0, ctrl_w[3:0]};
        if (!periodic && k >= n + 4) exp_ctrl[0] = 1'b0;
        read_reg(TM_CTRL, rd);
        checkOutput($sformatf("rand%0d_ctrl_k%0d", trial, k), rd, exp_ctrl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
